// File: rtl/sram_fill_check.sv
// sram_fill_check: write/read-back self-test sweep for one SRAM bank.
// Writes seed ^ addr to every word, reads each word back, and reports
// the mismatch count and the first failing address.
module sram_fill_check #(
   parameter  int unsigned NumWords  = 1024,
   parameter  int unsigned DataWidth = 32,
   localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   localparam int unsigned CntWidth  = AddrWidth + 1,
   localparam int unsigned BeWidth   = DataWidth / 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [DataWidth-1:0] seed_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic [CntWidth-1:0]  err_count_o,
   output logic                 first_err_valid_o,
   output logic [AddrWidth-1:0] first_err_addr_o,
   output logic                 req_o,
   output logic                 we_o,
   output logic [AddrWidth-1:0] addr_o,
   output logic [DataWidth-1:0] wdata_o,
   output logic [BeWidth-1:0]   be_o,
   input  logic [DataWidth-1:0] rdata_i
);

   localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      LAST  = 3'd3,
      DONE  = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] addr_d;
   logic                 req_d, we_d;
   logic [DataWidth-1:0] wdata_d;
   logic [DataWidth-1:0] seed_q, seed_d;
   logic                 busy_d, done_d, pass_d;
   logic [CntWidth-1:0]  err_count_d;
   logic                 first_err_valid_d;
   logic [AddrWidth-1:0] first_err_addr_d;
   logic                 cmp_valid_q, cmp_valid_d;
   logic [DataWidth-1:0] exp_q, exp_d;
   logic [AddrWidth-1:0] cmp_addr_q, cmp_addr_d;
   logic                 abort_active;
   logic                 mismatch;

   // Expected word content; address zero-extended or truncated to the word width.
   function automatic logic [DataWidth-1:0] pattern(input logic [DataWidth-1:0] s,
                                                    input logic [AddrWidth-1:0] a);
      return s ^ DataWidth'(a);
   endfunction

   // Byte enables are never partial during the sweep.
   assign be_o = '1;

   // Next-state, SRAM request and result bookkeeping.
   always_comb begin
      state_d           = state_q;
      addr_d            = addr_o;
      req_d             = 1'b0;
      we_d              = 1'b0;
      wdata_d           = '0;
      seed_d            = seed_q;
      busy_d            = busy_o;
      done_d            = 1'b0;
      pass_d            = pass_o;
      err_count_d       = err_count_o;
      first_err_valid_d = first_err_valid_o;
      first_err_addr_d  = first_err_addr_o;
      cmp_valid_d       = 1'b0;
      exp_d             = exp_q;
      cmp_addr_d        = cmp_addr_q;

      abort_active = abort_i && (state_q == WRITE || state_q == READ || state_q == LAST);
      mismatch     = cmp_valid_q && (rdata_i != exp_q) && !abort_active;

      if (mismatch) begin
         err_count_d = err_count_o + CntWidth'(1);
         if (!first_err_valid_o) begin
            first_err_valid_d = 1'b1;
            first_err_addr_d  = cmp_addr_q;
         end
      end

      case (state_q)
         IDLE: begin
            if (start_i && !abort_i) begin
               state_d           = WRITE;
               seed_d            = seed_i;
               err_count_d       = '0;
               first_err_valid_d = 1'b0;
               first_err_addr_d  = '0;
               pass_d            = 1'b0;
               busy_d            = 1'b1;
               addr_d            = '0;
               req_d             = 1'b1;
               we_d              = 1'b1;
               wdata_d           = pattern(seed_i, '0);
            end
         end
         WRITE: begin
            if (abort_i) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (addr_o == LastAddr) begin
               state_d = READ;
               addr_d  = '0;
               req_d   = 1'b1;
            end else begin
               addr_d  = addr_o + AddrWidth'(1);
               req_d   = 1'b1;
               we_d    = 1'b1;
               wdata_d = pattern(seed_q, addr_o + AddrWidth'(1));
            end
         end
         READ: begin
            if (abort_i) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               cmp_valid_d = 1'b1;
               exp_d       = pattern(seed_q, addr_o);
               cmp_addr_d  = addr_o;
               if (addr_o == LastAddr) begin
                  state_d = LAST;
               end else begin
                  addr_d = addr_o + AddrWidth'(1);
                  req_d  = 1'b1;
               end
            end
         end
         LAST: begin
            state_d = abort_i ? IDLE : DONE;
            busy_d  = 1'b0;
            if (!abort_i) begin
               done_d = 1'b1;
               pass_d = (err_count_d == '0);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q           <= IDLE;
         addr_o            <= '0;
         req_o             <= 1'b0;
         we_o              <= 1'b0;
         wdata_o           <= '0;
         seed_q            <= '0;
         busy_o            <= 1'b0;
         done_o            <= 1'b0;
         pass_o            <= 1'b0;
         err_count_o       <= '0;
         first_err_valid_o <= 1'b0;
         first_err_addr_o  <= '0;
         cmp_valid_q       <= 1'b0;
         exp_q             <= '0;
         cmp_addr_q        <= '0;
      end else begin
         state_q           <= state_d;
         addr_o            <= addr_d;
         req_o             <= req_d;
         we_o              <= we_d;
         wdata_o           <= wdata_d;
         seed_q            <= seed_d;
         busy_o            <= busy_d;
         done_o            <= done_d;
         pass_o            <= pass_d;
         err_count_o       <= err_count_d;
         first_err_valid_o <= first_err_valid_d;
         first_err_addr_o  <= first_err_addr_d;
         cmp_valid_q       <= cmp_valid_d;
         exp_q             <= exp_d;
         cmp_addr_q        <= cmp_addr_d;
      end
   end

endmodule

// File: tb/tb_sram_fill_check.sv
// Directed bench for sram_fill_check: 16-word bank with a faultable SRAM
// model, plus a 1-word bank for the single-word and mid-sweep reset cases.
module tb_sram_fill_check;

   localparam int unsigned NW  = 16;
   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 4;
   localparam int unsigned AW1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 16-word instance
   logic          rst, start, abort;
   logic [DW-1:0] seed;
   logic          busy, done, pass, first_err_valid, req, we;
   logic [AW:0]   err_count;
   logic [AW-1:0] first_err_addr, addr;
   logic [DW-1:0] wdata, rdata;
   logic [3:0]    be;

   // 1-word instance
   logic           rst_1, start_1, abort_1;
   logic [DW-1:0]  seed_1;
   logic           busy_1, done_1, pass_1, first_err_valid_1, req_1, we_1;
   logic [AW1:0]   err_count_1;
   logic [AW1-1:0] first_err_addr_1, addr_1;
   logic [DW-1:0]  wdata_1, rdata_1;
   logic [3:0]     be_1;

   int errors = 0;
   int checks = 0;
   int fault_mode = 0;

   logic [DW-1:0] mem [NW];
   logic [DW-1:0] mem1;

   sram_fill_check #(.NumWords(NW), .DataWidth(DW)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .seed_i(seed),
      .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err_count),
      .first_err_valid_o(first_err_valid), .first_err_addr_o(first_err_addr),
      .req_o(req), .we_o(we), .addr_o(addr), .wdata_o(wdata), .be_o(be),
      .rdata_i(rdata)
   );

   sram_fill_check #(.NumWords(1), .DataWidth(DW)) dut1 (
      .clk_i(clk), .rst_i(rst_1), .start_i(start_1), .abort_i(abort_1), .seed_i(seed_1),
      .busy_o(busy_1), .done_o(done_1), .pass_o(pass_1), .err_count_o(err_count_1),
      .first_err_valid_o(first_err_valid_1), .first_err_addr_o(first_err_addr_1),
      .req_o(req_1), .we_o(we_1), .addr_o(addr_1), .wdata_o(wdata_1), .be_o(be_1),
      .rdata_i(rdata_1)
   );

   // SRAM model, one-cycle read latency, optional read faults.
   always @(posedge clk) begin
      if (req === 1'b1 && we === 1'b1) mem[addr] <= wdata;
      if (req === 1'b1 && we === 1'b0) begin
         case (fault_mode)
            1:       rdata <= (addr == 4'd5) ? (mem[addr] ^ 32'h1) : mem[addr];
            2:       rdata <= (addr == 4'd3 || addr == 4'd9) ? '0 : mem[addr];
            default: rdata <= mem[addr];
         endcase
      end
   end

   always @(posedge clk) begin
      if (req_1 === 1'b1 && we_1 === 1'b1) mem1 <= wdata_1;
      if (req_1 === 1'b1 && we_1 === 1'b0) rdata_1 <= mem1;
   end

   // Starts a sweep on the 16-word instance and observes it cycle by cycle.
   task automatic run_sweep(input logic [DW-1:0] s, output int done_cyc, output int nwr,
                            output int nrd, output int seq_bad, output int busy_bad);
      done_cyc = -1; nwr = 0; nrd = 0; seq_bad = 0; busy_bad = 0;
      seed  = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         if (busy !== ((k <= 2 * NW + 1) ? 1'b1 : 1'b0)) busy_bad++;
         if (req === 1'b1 && we === 1'b1) begin
            if (addr !== AW'(nwr) || wdata !== (s ^ DW'(nwr))) seq_bad++;
            nwr++;
         end else if (req === 1'b1 && we === 1'b0) begin
            if (addr !== AW'(nrd)) seq_bad++;
            nrd++;
         end
         if (done === 1'b1) begin
            done_cyc = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rst_1 = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0; rst_1 = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, pass, first_err_valid, req, we} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, pass, first_err_valid, req, we});
      end
      checks++;
      if (err_count !== '0 || first_err_addr !== '0 || addr !== '0 || wdata !== '0) begin
         errors++; $display("FAIL reset_data: cnt=%0d ferr=%0d addr=%0d wdata=%h expected all 0", err_count, first_err_addr, addr, wdata);
      end
      checks++;
      if (be !== 4'hF) begin
         errors++; $display("FAIL reset_be: got %h expected f", be);
      end
      checks++;
      if ({busy_1, done_1, pass_1, req_1, we_1} !== 5'b0 || wdata_1 !== '0 || be_1 !== 4'hF) begin
         errors++; $display("FAIL reset_single: ctrl=%b wdata=%h be=%h expected 00000/0/f", {busy_1, done_1, pass_1, req_1, we_1}, wdata_1, be_1);
      end
   endtask

   task automatic test_clean();
      int dc, nw, nr, sb, bb;
      fault_mode = 0;
      run_sweep(32'hA5A5_0000, dc, nw, nr, sb, bb);
      checks++;
      if (dc !== 34) begin errors++; $display("FAIL clean_done_cycle: got %0d expected 34", dc); end
      checks++;
      if (nw !== 16 || nr !== 16) begin errors++; $display("FAIL clean_counts: writes=%0d reads=%0d expected 16/16", nw, nr); end
      checks++;
      if (sb !== 0) begin errors++; $display("FAIL clean_seq: %0d bad addr/data cycles expected 0", sb); end
      checks++;
      if (bb !== 0) begin errors++; $display("FAIL clean_busy: %0d bad busy cycles expected 0", bb); end
      checks++;
      if (pass !== 1'b1 || err_count !== 5'd0 || first_err_valid !== 1'b0) begin
         errors++; $display("FAIL clean_result: pass=%b cnt=%0d fv=%b expected 1/0/0", pass, err_count, first_err_valid);
      end
   endtask

   task automatic test_flip_word5();
      int dc, nw, nr, sb, bb;
      fault_mode = 1;
      @(negedge clk);
      run_sweep(32'hA5A5_0000, dc, nw, nr, sb, bb);
      checks++;
      if (dc !== 34) begin errors++; $display("FAIL flip_done_cycle: got %0d expected 34", dc); end
      checks++;
      if (pass !== 1'b0 || err_count !== 5'd1) begin
         errors++; $display("FAIL flip_result: pass=%b cnt=%0d expected 0/1", pass, err_count);
      end
      checks++;
      if (first_err_valid !== 1'b1 || first_err_addr !== 4'd5) begin
         errors++; $display("FAIL flip_first: fv=%b addr=%0d expected 1/5", first_err_valid, first_err_addr);
      end
   endtask

   task automatic test_zero_words();
      int dc, nw, nr, sb, bb;
      fault_mode = 2;
      @(negedge clk);
      run_sweep(32'h1234_5678, dc, nw, nr, sb, bb);
      checks++;
      if (pass !== 1'b0 || err_count !== 5'd2) begin
         errors++; $display("FAIL zero_result: pass=%b cnt=%0d expected 0/2", pass, err_count);
      end
      checks++;
      if (first_err_valid !== 1'b1 || first_err_addr !== 4'd3) begin
         errors++; $display("FAIL zero_first: fv=%b addr=%0d expected 1/3", first_err_valid, first_err_addr);
      end
      fault_mode = 0;
   endtask

   task automatic test_abort();
      int dc, nw, nr, sb, bb;
      logic saw_done;
      @(negedge clk);
      seed = 32'hA5A5_0000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      checks++;
      if (req !== 1'b1 || we !== 1'b0) begin
         errors++; $display("FAIL abort_pre: req=%b we=%b expected 1/0", req, we);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
         errors++; $display("FAIL abort_stop: req=%b busy=%b done=%b pass=%b expected 0/0/0/0", req, busy, done, pass);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1 || req === 1'b1) saw_done = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_quiet: activity=%b expected 0", saw_done); end
      run_sweep(32'h0F0F_F0F0, dc, nw, nr, sb, bb);
      checks++;
      if (dc !== 34 || pass !== 1'b1 || err_count !== 5'd0 || sb !== 0) begin
         errors++; $display("FAIL abort_rerun: done_cyc=%0d pass=%b cnt=%0d seq_bad=%0d expected 34/1/0/0", dc, pass, err_count, sb);
      end
   endtask

   task automatic test_start_held();
      int ndone, nw;
      @(negedge clk);
      ndone = 0; nw = 0;
      seed = 32'h5555_AAAA;
      start = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (k == 34) start = 1'b0;
         if (done === 1'b1) ndone++;
         if (req === 1'b1 && we === 1'b1) nw++;
      end
      checks++;
      if (ndone !== 1 || nw !== 16) begin
         errors++; $display("FAIL held_start: done_pulses=%0d writes=%0d expected 1/16", ndone, nw);
      end
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || req !== 1'b0 || pass !== 1'b1) begin
         errors++; $display("FAIL start_abort_idle: busy=%b req=%b pass=%b expected 0/0/1", busy, req, pass);
      end
   endtask

   task automatic test_single_word();
      @(negedge clk);
      seed_1 = 32'hFFFF_FFFF;
      start_1 = 1'b1;
      @(negedge clk);
      start_1 = 1'b0;
      checks++;
      if (req_1 !== 1'b1 || we_1 !== 1'b1 || addr_1 !== 1'b0 || wdata_1 !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL single_write: req=%b we=%b addr=%0d wdata=%h expected 1/1/0/ffffffff", req_1, we_1, addr_1, wdata_1);
      end
      @(negedge clk);
      checks++;
      if (req_1 !== 1'b1 || we_1 !== 1'b0 || addr_1 !== 1'b0) begin
         errors++; $display("FAIL single_read: req=%b we=%b addr=%0d expected 1/0/0", req_1, we_1, addr_1);
      end
      @(negedge clk);
      checks++;
      if (req_1 !== 1'b0 || busy_1 !== 1'b1 || done_1 !== 1'b0) begin
         errors++; $display("FAIL single_last: req=%b busy=%b done=%b expected 0/1/0", req_1, busy_1, done_1);
      end
      @(negedge clk);
      checks++;
      if (done_1 !== 1'b1 || pass_1 !== 1'b1 || err_count_1 !== 2'd0 || busy_1 !== 1'b0) begin
         errors++; $display("FAIL single_done: done=%b pass=%b cnt=%0d busy=%b expected 1/1/0/0", done_1, pass_1, err_count_1, busy_1);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      seed_1 = 32'h0000_0001;
      start_1 = 1'b1;
      @(negedge clk);
      start_1 = 1'b0;
      @(negedge clk);
      checks++;
      if (req_1 !== 1'b1 || we_1 !== 1'b0 || busy_1 !== 1'b1) begin
         errors++; $display("FAIL midrst_pre: req=%b we=%b busy=%b expected 1/0/1", req_1, we_1, busy_1);
      end
      rst_1 = 1'b1;
      @(negedge clk);
      rst_1 = 1'b0;
      checks++;
      if ({busy_1, done_1, pass_1, first_err_valid_1, req_1, we_1} !== 6'b0 || err_count_1 !== '0 ||
          addr_1 !== '0 || wdata_1 !== '0 || first_err_addr_1 !== '0 || be_1 !== 4'hF) begin
         errors++; $display("FAIL midrst_vals: ctrl=%b cnt=%0d addr=%0d wdata=%h be=%h expected 000000/0/0/0/f",
                            {busy_1, done_1, pass_1, first_err_valid_1, req_1, we_1}, err_count_1, addr_1, wdata_1, be_1);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy_1 !== 1'b0 || req_1 !== 1'b0 || done_1 !== 1'b0) begin
         errors++; $display("FAIL midrst_idle: busy=%b req=%b done=%b expected 0/0/0", busy_1, req_1, done_1);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; seed = '0;
      rst_1 = 1'b1; start_1 = 1'b0; abort_1 = 1'b0; seed_1 = '0;
      @(negedge clk);
      test_reset();
      test_clean();
      test_flip_word5();
      test_zero_words();
      test_abort();
      test_start_held();
      test_single_word();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
